// File: rtl/lvds_data_wr_ctrl.sv
// lvds_data_wr_ctrl: packs RGB888 line bytes into four 16-bit lane FIFOs
// and emits one line-control code per line/timing event into the vshsde FIFO.
module lvds_data_wr_ctrl #(
  parameter int          LCD_H_WIDTH = 16,
  parameter int          NUM_LINE_RD = (LCD_H_WIDTH * 3) / 8,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter logic [7:0]  DES_VALID   = 8'hFF,
  parameter logic [7:0]  DES_INVALID = 8'h0F,
  parameter logic [7:0]  DVS_VALID   = 8'hF0
) (
  input  logic        I_lcd_clk,
  input  logic        I_rst_n,
  input  logic        I_lcd_de,
  input  logic        I_lcd_hs,
  input  logic        I_lcd_vs,
  input  logic [7:0]  I_lcd_r,
  input  logic [7:0]  I_lcd_g,
  input  logic [7:0]  I_lcd_b,
  output logic        O_rgb_lane0_wren,
  output logic        O_rgb_lane1_wren,
  output logic        O_rgb_lane2_wren,
  output logic        O_rgb_lane3_wren,
  output logic [15:0] O_rgb_lane0_data,
  output logic [15:0] O_rgb_lane1_data,
  output logic [15:0] O_rgb_lane2_data,
  output logic [15:0] O_rgb_lane3_data,
  input  logic        I_full_lane0,
  input  logic        I_full_lane1,
  input  logic        I_full_lane2,
  input  logic        I_full_lane3,
  output logic        O_vshsde_wren,
  output logic [7:0]  O_vshsde_ctrl,
  input  logic        I_full_vshsde,
  output logic        O_ovf,
  output logic        O_line_err
);
  localparam int PW = $clog2(LCD_H_WIDTH + 1);
  localparam int WW = $clog2(NUM_LINE_RD + 1);
  localparam logic [PW-1:0] W_L   = PW'(LCD_H_WIDTH);
  localparam logic [WW-1:0] NUM_L = WW'(NUM_LINE_RD);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAD, CTRL} state_t;
  state_t state, state_nx;

  logic [PW-1:0] pix_cnt;
  logic [WW-1:0] words;
  logic [7:0]    res_q [8];
  logic [7:0]    nres  [8];
  logic [7:0]    word  [8];
  logic [7:0]    pix   [3];
  logic [15:0]   lane_q [4];
  logic          de_q, hs_q, vs_q, seen_de, wren_q;
  logic [2:0]    pend, allp, sel;
  logic          start, take, wr_data, pad_wr, lane_wr, full_any;
  logic          post_dv, err_set, hs_e, vs_e, ctrl_any;
  logic [2:0]    phase, pos;
  logic [3:0]    k;
  logic [7:0]    code;

  assign start    = (state == IDLE || state == CTRL) && I_lcd_de && !de_q;
  assign take     = start || (state == ACTIVE && I_lcd_de && pix_cnt < W_L);
  assign phase    = start ? 3'd0 : pix_cnt[2:0];
  assign pos      = 3'(phase * 3);
  assign wr_data  = take && (phase == 3'd2 || phase == 3'd5 || phase == 3'd7);
  assign pad_wr   = state == PAD && words != NUM_L;
  assign lane_wr  = wr_data || pad_wr;
  assign full_any = I_full_lane0 | I_full_lane1 | I_full_lane2 | I_full_lane3;
  assign pix      = '{I_lcd_r, I_lcd_g, I_lcd_b};

  // Bytes landing past position 7 complete the word and become the next residual.
  always_comb begin
    word = res_q;
    nres = res_q;
    k    = 4'd0;
    for (int j = 0; j < 3; j++) begin
      k = {1'b0, pos} + 4'(j);
      nres[k[2:0]] = pix[j];
      if (!k[3]) word[k[2:0]] = pix[j];
    end
  end

  always_comb begin
    state_nx = state;
    post_dv  = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE:   state_nx = start ? ACTIVE : IDLE;
      ACTIVE: begin
        if (!I_lcd_de) begin
          post_dv  = words == NUM_L;
          err_set  = words != NUM_L;
          state_nx = words == NUM_L ? CTRL : PAD;
        end else err_set = pix_cnt >= W_L;
      end
      PAD: begin
        err_set  = I_lcd_de;
        post_dv  = words == NUM_L;
        state_nx = words == NUM_L ? CTRL : PAD;
      end
      default: state_nx = start ? ACTIVE : IDLE;
    endcase
  end

  assign hs_e     = I_lcd_hs == HS_POL && hs_q != HS_POL;
  assign vs_e     = I_lcd_vs == VS_POL && vs_q != VS_POL;
  assign allp     = pend | {post_dv, vs_e, hs_e && !vs_e && !seen_de};
  assign sel      = allp[2] ? 3'b100 : allp[1] ? 3'b010 : allp[0] ? 3'b001 : 3'b000;
  assign code     = allp[2] ? DES_VALID : allp[1] ? DVS_VALID : DES_INVALID;
  assign ctrl_any = |allp;

  always_ff @(posedge I_lcd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= IDLE;
      pix_cnt       <= '0;
      words         <= '0;
      res_q         <= '{default: '0};
      lane_q        <= '{default: '0};
      wren_q        <= 1'b0;
      de_q          <= 1'b0;
      hs_q          <= HS_POL;
      vs_q          <= VS_POL;
      seen_de       <= 1'b0;
      pend          <= '0;
      O_vshsde_wren <= 1'b0;
      O_vshsde_ctrl <= '0;
      O_ovf         <= 1'b0;
      O_line_err    <= 1'b0;
    end else begin
      state   <= state_nx;
      pix_cnt <= start ? PW'(1) : pix_cnt + PW'(take);
      words   <= start ? '0 : words + WW'(lane_wr);
      if (take) res_q <= nres;
      wren_q  <= lane_wr && !full_any;
      if (lane_wr && !full_any)
        for (int n = 0; n < 4; n++) lane_q[n] <= pad_wr ? 16'h0 : {word[n+4], word[n]};
      de_q          <= I_lcd_de;
      hs_q          <= I_lcd_hs;
      vs_q          <= I_lcd_vs;
      seen_de       <= hs_e ? 1'b0 : seen_de | I_lcd_de;
      pend          <= allp & ~sel;
      O_vshsde_wren <= ctrl_any && !I_full_vshsde;
      if (ctrl_any && !I_full_vshsde) O_vshsde_ctrl <= code;
      O_ovf         <= O_ovf | (ctrl_any && I_full_vshsde) | (lane_wr && full_any);
      O_line_err    <= O_line_err | err_set;
    end
  end

  assign O_rgb_lane0_wren = wren_q;
  assign O_rgb_lane1_wren = wren_q;
  assign O_rgb_lane2_wren = wren_q;
  assign O_rgb_lane3_wren = wren_q;
  assign O_rgb_lane0_data = lane_q[0];
  assign O_rgb_lane1_data = lane_q[1];
  assign O_rgb_lane2_data = lane_q[2];
  assign O_rgb_lane3_data = lane_q[3];
endmodule

// File: tb/tb_lvds_data_wr_ctrl.sv
// tb_lvds_data_wr_ctrl: line vectors and random lines checked against a
// byte-array model of the lane packing, plus control-event sequences.
module tb_lvds_data_wr_ctrl;
  localparam int W = 16, NUM = 6;

  logic clk = 0, rst_n = 0, de = 0, hs = 0, vs = 0, full_v = 0;
  logic [7:0] r = 0, g = 0, b = 0;
  logic [3:0] full = 0;
  logic w0, w1, w2, w3, vwren, ovf, lerr;
  logic [15:0] d0, d1, d2, d3;
  logic [7:0] ctrl;

  lvds_data_wr_ctrl #(.LCD_H_WIDTH(W)) dut (
    .I_lcd_clk(clk), .I_rst_n(rst_n), .I_lcd_de(de), .I_lcd_hs(hs), .I_lcd_vs(vs),
    .I_lcd_r(r), .I_lcd_g(g), .I_lcd_b(b),
    .O_rgb_lane0_wren(w0), .O_rgb_lane1_wren(w1), .O_rgb_lane2_wren(w2), .O_rgb_lane3_wren(w3),
    .O_rgb_lane0_data(d0), .O_rgb_lane1_data(d1), .O_rgb_lane2_data(d2), .O_rgb_lane3_data(d3),
    .I_full_lane0(full[0]), .I_full_lane1(full[1]), .I_full_lane2(full[2]), .I_full_lane3(full[3]),
    .O_vshsde_wren(vwren), .O_vshsde_ctrl(ctrl), .I_full_vshsde(full_v),
    .O_ovf(ovf), .O_line_err(lerr)
  );

  always #5 clk = ~clk;

  typedef struct {int c; logic [63:0] d;} wr_t;
  typedef struct {int c; logic [7:0] code;} cw_t;
  typedef struct {int npix; int full_at; bit seq;} vec_t;

  int cyc = 0, checks = 0, passes = 0;
  bit ovf_m = 0, err_m = 0;
  wr_t lw_q[$], exp_w[$];
  cw_t cw_q[$], exp_c[$];
  logic [7:0] bytes [64];
  vec_t vecs [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  always @(negedge clk) begin
    wr_t lw;
    cw_t cw;
    if (rst_n) begin
      if (w0 | w1 | w2 | w3) begin
        chk("lane_wren_equal", {w0, w1, w2, w3}, 4'hF);
        lw.c = cyc; lw.d = {d3, d2, d1, d0};
        lw_q.push_back(lw);
      end
      if (vwren) begin
        cw.c = cyc; cw.code = ctrl;
        cw_q.push_back(cw);
      end
    end
  end

  task automatic compare(input string tag);
    chk({tag, "_nwords"}, lw_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < lw_q.size(); i++) begin
      chk({tag, "_word"}, lw_q[i].d, exp_w[i].d);
      chk({tag, "_wcyc"}, lw_q[i].c, exp_w[i].c);
    end
    chk({tag, "_nctrl"}, cw_q.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < cw_q.size(); i++) begin
      chk({tag, "_code"}, cw_q[i].code, exp_c[i].code);
      chk({tag, "_ccyc"}, cw_q[i].c, exp_c[i].c);
    end
    chk({tag, "_ovf"}, ovf, ovf_m);
    chk({tag, "_line_err"}, lerr, err_m);
    lw_q.delete(); cw_q.delete(); exp_w.delete(); exp_c.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1 chk("reset_outputs", {w0, w1, w2, w3, d0, d1, d2, d3, vwren, ctrl, ovf, lerr}, '0);
    @(negedge clk);
    rst_n = 1;
    ovf_m = 0; err_m = 0;
    lw_q.delete(); cw_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Expected words come from the byte stream: word k lane n = {byte 8k+n+4, byte 8k+n}.
  task automatic run_line(input int npix, input int full_at, input bit seq, input string tag);
    int p = 0, real_w, pads, taken;
    wr_t e;
    cw_t c;
    taken = npix < W ? npix : W;
    for (int j = 0; j < 3 * npix; j++) bytes[j] = seq ? 8'(j + 1) : 8'($urandom);
    real_w = (3 * taken) / 8;
    if (real_w > NUM) real_w = NUM;
    pads = NUM - real_w;
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      if (i == 0) p = cyc + 1;
      de = 1; r = bytes[3*i]; g = bytes[3*i+1]; b = bytes[3*i+2];
      full = (full_at >= 0 && i == (8 * full_at + 7) / 3) ? 4'b0100 : 4'b0000;
    end
    @(negedge clk);
    de = 0; full = 0;
    repeat (NUM + 6) @(negedge clk);
    for (int k = 0; k < real_w; k++)
      if (k != full_at) begin
        e.c = p + (8 * k + 7) / 3;
        for (int n = 0; n < 4; n++) e.d[16*n +: 16] = {bytes[8*k+n+4], bytes[8*k+n]};
        exp_w.push_back(e);
      end
    for (int q = 0; q < pads; q++) begin
      e.c = p + npix + 1 + q; e.d = '0;
      exp_w.push_back(e);
    end
    c.c = p + npix + (pads > 0 ? pads + 1 : 0); c.code = 8'hFF;
    exp_c.push_back(c);
    if (full_at >= 0 && full_at < real_w) ovf_m = 1;
    if (npix != W) err_m = 1;
    if (seq && npix == W && full_at < 0 && lw_q.size() == NUM) begin
      chk("first_word", lw_q[0].d, 64'h0804_0703_0602_0501);
      chk("last_lane3", lw_q[5].d[63:48], 16'h302C);
    end
    compare(tag);
  endtask

  task automatic ev_pulse(input bit with_vs, input bit expect_w, input logic [7:0] code, input string tag);
    int p;
    cw_t c;
    @(negedge clk);
    hs = 1; vs = with_vs; p = cyc + 1;
    repeat (2) @(negedge clk);
    hs = 0; vs = 0;
    repeat (4) @(negedge clk);
    if (expect_w) begin
      c.c = p; c.code = code;
      exp_c.push_back(c);
    end
    compare(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16, -1, 1};
    vecs[1] = '{10, -1, 1};
    vecs[2] = '{20, -1, 1};
    vecs[3] = '{16,  1, 1};
    vecs[4] = '{ 8, -1, 0};
    vecs[5] = '{17,  3, 0};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_line(vecs[v].npix, vecs[v].full_at, vecs[v].seq, $sformatf("vec%0d", v));
    end

    do_reset();
    ev_pulse(0, 1, 8'h0F, "hs_no_de");
    ev_pulse(0, 1, 8'h0F, "hs_no_de2");
    ev_pulse(1, 1, 8'hF0, "hs_vs");
    run_line(16, -1, 0, "pre_hs");
    ev_pulse(0, 0, 8'h00, "hs_after_de");
    ev_pulse(0, 1, 8'h0F, "hs_again");
    full_v = 1;
    ovf_m = 1;
    ev_pulse(0, 0, 8'h00, "ctrl_full");
    full_v = 0;

    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      de = 1; r = 8'(i); g = 8'hA5; b = 8'h5A;
    end
    @(negedge clk);
    rst_n = 0; de = 0;
    #1 chk("midline_reset", {w0, w1, w2, w3, d0, d1, d2, d3, vwren, ctrl, ovf, lerr}, '0);
    @(negedge clk);
    rst_n = 1; ovf_m = 0; err_m = 0;
    lw_q.delete(); cw_q.delete();
    repeat (2) @(negedge clk);
    run_line(16, -1, 1, "after_reset");

    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      run_line($urandom_range(1, 20), int'($urandom_range(0, 7)) - 1, 0, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
